cpu_io_responder: RTL and testbench

- Operator-side I/O responder facing the 8-bit accumulator CPU's console interface.
- Input direction: conditions a raw push-button and the 8 data switches into a clean, one-cycle Enter pulse and a stable Input byte, issued only while the CPU is waiting in an IN instruction.
- Output direction: captures each CPU output write into a 4-deep history for display.
- Tracks Halt and suppresses all further input once the CPU has halted.

---
 rtl/cpu_io_responder_if.sv | 44 ++++
 rtl/cpu_io_responder.sv | 137 +++++++++++++
 tb/tb_cpu_io_responder.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_io_responder_if.sv
// Console bus between the accumulator CPU (plus operator hardware) and the
// I/O responder.
//   master : drives the key, switches, CPU handshake and history select;
//            observes Enter/Input/Waiting and the display outputs.
//   slave  : the responder; sees those inputs and drives the outputs.
// Signals:
//   key_raw      raw push-button, active-high, asynchronous, bouncy
//   switches     raw 8-bit data switches, asynchronous
//   in_req       CPU is executing IN and waiting for Enter
//   cpu_output   CPU output register value
//   out_strobe   one-cycle pulse: cpu_output written this cycle
//   halt         CPU halted (level)
//   hist_sel     history index, 0 = newest
//   enter        one-cycle input-accept pulse to the CPU
//   input_byte   latched switch byte to the CPU
//   waiting      high while armed for an operator press
//   out_hist     history entry selected by hist_sel
//   out_count    number of valid history entries, 0..4
//   halt_seen    sticky halt flag
interface cpu_io_responder_if;
  logic       key_raw;
  logic [7:0] switches;
  logic       in_req;
  logic [7:0] cpu_output;
  logic       out_strobe;
  logic       halt;
  logic [1:0] hist_sel;
  logic       enter;
  logic [7:0] input_byte;
  logic       waiting;
  logic [7:0] out_hist;
  logic [2:0] out_count;
  logic       halt_seen;

  modport master (
    output key_raw, switches, in_req, cpu_output, out_strobe, halt, hist_sel,
    input  enter, input_byte, waiting, out_hist, out_count, halt_seen
  );

  modport slave (
    input  key_raw, switches, in_req, cpu_output, out_strobe, halt, hist_sel,
    output enter, input_byte, waiting, out_hist, out_count, halt_seen
  );
endinterface

// File: rtl/cpu_io_responder.sv
// Operator-side I/O responder for the accumulator CPU console.
// Conditions the raw key and switches into a single Enter pulse plus a
// stable Input byte while the CPU waits in IN, keeps a 4-deep history of CPU
// output writes, and locks out input once the CPU halts.
// Ports:
//   clk_i   system clock, rising edge
//   rst_ni  asynchronous active-low reset
//   bus     console interface (slave side), see cpu_io_responder_if
// Parameters:
//   DEB_CYCLES  stable synchronized-key cycles needed to flip the debounced key
//   DEB_W       debounce counter width, must hold DEB_CYCLES
module cpu_io_responder #(
  parameter int DEB_CYCLES = 16,
  parameter int DEB_W      = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  cpu_io_responder_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    FIRE,
    WAIT_REL,
    HALTED
  } state_e;

  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  function automatic logic [2:0] sat_inc4(input logic [2:0] c);
    return (c == 3'd4) ? c : c + 3'd1;
  endfunction

  logic             key_s1_q, key_s2_q;
  logic [7:0]       sw_s1_q, sw_s2_q;
  logic             deb_q, deb_d;
  logic [DEB_W-1:0] cnt_q, cnt_d;
  state_e           state_q, state_d;
  logic [7:0]       input_q, input_d;
  logic             halt_seen_q;
  logic [7:0]       hist_q [4];
  logic [2:0]       count_q;

  // Two-flop synchronizers for the key and every switch bit
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      key_s1_q <= 1'b0;
      key_s2_q <= 1'b0;
      sw_s1_q  <= 8'h00;
      sw_s2_q  <= 8'h00;
    end else begin
      key_s1_q <= bus.key_raw;
      key_s2_q <= key_s1_q;
      sw_s1_q  <= bus.switches;
      sw_s2_q  <= sw_s1_q;
    end
  end

  // Debounce: the debounced key only flips after DEB_CYCLES consecutive
  // disagreeing cycles; any agreeing cycle restarts the count.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (key_s2_q != deb_q) begin
      if (cnt_q == DEB_LAST) begin
        deb_d = ~deb_q;
      end else begin
        cnt_d = cnt_q + DEB_W'(1);
      end
    end
  end

  // Press FSM. ARMED is only entered with the debounced key low, so seeing
  // it high there means a fresh press.
  always_comb begin
    state_d = state_q;
    input_d = input_q;
    if (bus.halt) begin
      state_d = HALTED;
    end else begin
      case (state_q)
        IDLE:     if (bus.in_req && !deb_q) state_d = ARMED;
        ARMED: begin
          if (deb_q) begin
            state_d = FIRE;
            input_d = sw_s2_q;
          end else if (!bus.in_req) begin
            state_d = IDLE;
          end
        end
        FIRE:     state_d = WAIT_REL;
        WAIT_REL: if (!deb_q) state_d = IDLE;
        HALTED:   state_d = HALTED;
        default:  state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      deb_q       <= 1'b0;
      cnt_q       <= '0;
      state_q     <= IDLE;
      input_q     <= 8'h00;
      halt_seen_q <= 1'b0;
    end else begin
      deb_q       <= deb_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      input_q     <= input_d;
      if (bus.halt) halt_seen_q <= 1'b1;
    end
  end

  // Output history shift register; strobes are taken in every state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 4; i++) hist_q[i] <= 8'h00;
      count_q <= 3'd0;
    end else if (bus.out_strobe) begin
      hist_q[3] <= hist_q[2];
      hist_q[2] <= hist_q[1];
      hist_q[1] <= hist_q[0];
      hist_q[0] <= bus.cpu_output;
      count_q   <= sat_inc4(count_q);
    end
  end

  assign bus.enter      = (state_q == FIRE);
  assign bus.waiting    = (state_q == ARMED);
  assign bus.input_byte = input_q;
  assign bus.halt_seen  = halt_seen_q;
  assign bus.out_count  = count_q;
  assign bus.out_hist   = hist_q[bus.hist_sel];

endmodule

// File: tb/tb_cpu_io_responder.sv
module tb_cpu_io_responder;
  localparam int DEB = 4;

  logic clk;
  logic rst_n;
  int   cyc;

  cpu_io_responder_if bus ();

  cpu_io_responder #(
    .DEB_CYCLES (DEB),
    .DEB_W      (16)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         checks;
  int         fails;
  int         enter_cnt;
  int         last_enter_cyc;
  logic       prev_en;
  logic [7:0] exp_q[$];
  logic [7:0] hist_m[$];
  logic [7:0] popped;
  int         c0;
  int         n0;
  logic [7:0] sw;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_waiting(input int budget);
    int k;
    k = 0;
    while (bus.waiting !== 1'b1 && k < budget) begin
      tick(1);
      k++;
    end
    chk("waiting_within_budget", bus.waiting, 1);
  endtask

  task automatic strobe(input logic [7:0] v);
    bus.cpu_output = v;
    bus.out_strobe = 1'b1;
    tick(1);
    bus.out_strobe = 1'b0;
    hist_m.push_front(v);
  endtask

  task automatic check_hist();
    int n;
    n = (hist_m.size() > 4) ? 4 : hist_m.size();
    chk("out_count", bus.out_count, n);
    for (int i = 0; i < 4; i++) begin
      bus.hist_sel = i[1:0];
      #1;
      chk($sformatf("out_hist[%0d]", i), bus.out_hist, (i < hist_m.size()) ? hist_m[i] : 8'h00);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; fails = 0; enter_cnt = 0; last_enter_cyc = -1; prev_en = 1'b0;
    rst_n = 1'b0;
    bus.key_raw = 1'b0; bus.switches = 8'h00; bus.in_req = 1'b0;
    bus.cpu_output = 8'h00; bus.out_strobe = 1'b0; bus.halt = 1'b0; bus.hist_sel = 2'd0;

    // Scoreboard monitor: every Enter pops the expected Input byte
    fork
      forever begin
        @(negedge clk);
        if (bus.enter === 1'b1) begin
          enter_cnt++;
          last_enter_cyc = cyc;
          chk("enter_single_cycle", prev_en, 0);
          chk("enter_has_expectation", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            popped = exp_q.pop_front();
            chk("enter_input_byte", bus.input_byte, popped);
          end
        end
        prev_en = bus.enter;
      end
    join_none

    // Reset values
    tick(2);
    chk("rst_enter", bus.enter, 0);
    chk("rst_input", bus.input_byte, 8'h00);
    chk("rst_waiting", bus.waiting, 0);
    chk("rst_halt_seen", bus.halt_seen, 0);
    chk("rst_out_count", bus.out_count, 0);
    chk("rst_out_hist", bus.out_hist, 8'h00);
    rst_n = 1'b1;
    tick(2);

    // Clean press, latency and capture
    bus.switches = 8'h5A;
    bus.in_req = 1'b1;
    tick(4);
    chk("waiting_before_press", bus.waiting, 1);
    exp_q.push_back(8'h5A);
    bus.key_raw = 1'b1;
    c0 = cyc;
    tick(DEB + 8);
    chk("enter_latency", last_enter_cyc - c0, 2 + DEB + 1);
    chk("enter_count_clean", enter_cnt, 1);
    chk("input_5a", bus.input_byte, 8'h5A);
    chk("waiting_after_fire", bus.waiting, 0);
    bus.switches = 8'hFF;
    tick(10);
    chk("input_holds_5a", bus.input_byte, 8'h5A);
    bus.key_raw = 1'b0;
    tick(DEB + 6);

    // Bouncy press, long hold with InReq re-pulsed
    bus.switches = 8'h3C;
    wait_waiting(20);
    n0 = enter_cnt;
    exp_q.push_back(8'h3C);
    for (int i = 0; i < 10; i++) begin
      bus.key_raw = ~bus.key_raw;
      tick(2);
    end
    bus.key_raw = 1'b1;
    tick(DEB + 8);
    chk("bounce_one_enter", enter_cnt - n0, 1);
    bus.in_req = 1'b0;
    tick(5);
    bus.in_req = 1'b1;
    tick(95);
    chk("hold_no_second_enter", enter_cnt - n0, 1);
    chk("hold_not_waiting", bus.waiting, 0);
    bus.key_raw = 1'b0;
    tick(DEB + 6);
    chk("rearmed_after_release", bus.waiting, 1);
    bus.switches = 8'hC3;
    tick(3);
    exp_q.push_back(8'hC3);
    bus.key_raw = 1'b1;
    tick(DEB + 8);
    chk("new_press_enter", enter_cnt - n0, 2);
    bus.key_raw = 1'b0;
    tick(DEB + 6);

    // Key already held when InReq rises
    bus.in_req = 1'b0;
    tick(3);
    bus.key_raw = 1'b1;
    tick(DEB + 6);
    n0 = enter_cnt;
    bus.in_req = 1'b1;
    tick(20);
    chk("preheld_not_armed", bus.waiting, 0);
    chk("preheld_no_enter", enter_cnt - n0, 0);
    bus.key_raw = 1'b0;
    tick(DEB + 6);
    chk("preheld_armed_after_release", bus.waiting, 1);
    bus.switches = 8'h96;
    tick(3);
    exp_q.push_back(8'h96);
    bus.key_raw = 1'b1;
    tick(DEB + 8);
    chk("preheld_new_press_enter", enter_cnt - n0, 1);
    bus.key_raw = 1'b0;
    tick(DEB + 6);

    // Randomized presses with short bounce runs
    n0 = enter_cnt;
    for (int it = 0; it < 8; it++) begin
      sw = 8'($urandom);
      bus.switches = sw;
      wait_waiting(30);
      tick(3);
      exp_q.push_back(sw);
      for (int j = 0; j < int'($urandom_range(0, 6)); j++) begin
        bus.key_raw = ~bus.key_raw;
        tick($urandom_range(1, DEB - 1));
      end
      bus.key_raw = 1'b1;
      tick(DEB + 8);
      bus.switches = 8'($urandom);
      tick(5);
      chk("rand_input_holds", bus.input_byte, sw);
      bus.key_raw = 1'b0;
      tick(DEB + 6 + $urandom_range(0, 3));
    end
    chk("rand_enter_count", enter_cnt - n0, 8);

    // Output history
    strobe(8'd1);
    strobe(8'd2);
    check_hist();
    for (int v = 3; v <= 6; v++) strobe(v[7:0]);
    check_hist();
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < int'($urandom_range(1, 3)); k++) strobe(8'($urandom));
      check_hist();
    end

    // Halt while armed with a press in progress
    bus.switches = 8'h11;
    wait_waiting(30);
    n0 = enter_cnt;
    bus.key_raw = 1'b1;
    tick(3);
    bus.halt = 1'b1;
    bus.cpu_output = 8'h77;
    bus.out_strobe = 1'b1;
    tick(1);
    bus.out_strobe = 1'b0;
    hist_m.push_front(8'h77);
    chk("halt_seen_set", bus.halt_seen, 1);
    chk("halt_not_waiting", bus.waiting, 0);
    tick(DEB + 8);
    bus.key_raw = 1'b0;
    tick(DEB + 6);
    bus.key_raw = 1'b1;
    tick(DEB + 8);
    chk("halt_no_enter", enter_cnt - n0, 0);
    bus.key_raw = 1'b0;
    bus.hist_sel = 2'd0;
    #1;
    chk("halt_strobe_h0", bus.out_hist, 8'h77);
    strobe(8'h78);
    check_hist();
    bus.halt = 1'b0;
    tick(5);
    chk("halt_seen_sticky", bus.halt_seen, 1);
    chk("halted_absorbing", bus.waiting, 0);

    // Reset pulse during FIRE
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    hist_m.delete();
    tick(2);
    bus.switches = 8'hA5;
    bus.in_req = 1'b1;
    wait_waiting(30);
    bus.key_raw = 1'b1;
    tick(2 + DEB + 1);
    chk("enter_in_fire", bus.enter, 1);
    #1;
    rst_n = 1'b0;
    bus.key_raw = 1'b0;
    #1;
    chk("reset_kills_enter", bus.enter, 0);
    chk("reset_input", bus.input_byte, 8'h00);
    chk("reset_out_count", bus.out_count, 0);
    chk("reset_waiting", bus.waiting, 0);
    chk("reset_halt_seen", bus.halt_seen, 0);
    tick(1);
    rst_n = 1'b1;
    tick(DEB + 8);
    check_hist();

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
